dm_bus_arbiter: RTL and testbench
=================================

Name: dm_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the single external data-memory/IO bus.
- Port 0 is the CPU load/store side: dm_cs/dm_wr/dm_rd, ALU_OUT as the address, D_OUT as write data.
- Port 1 is a secondary master, e.g. a DMA or boot loader.
- Grants one access at a time using round-robin on ties, holds the memory strobes for a fixed access time, latches read data, and returns a one-cycle ready pulse to the owner.

Parameters:
AW, 32, address width
DW, 32, data width
ACC_CYC, 2, cycles the memory strobes are held per access (legal range 1..15)

Ports:
clk  in  1  system clock
reset  in  1  one clock; reset is asynchronous and active-low
req0_cs  in  1  port 0 request
req0_wr  in  1  port 0 write
req0_rd  in  1  port 0 read
req0_addr  in  AW  port 0 address
req0_din  in  DW  port 0 write data
req1_cs  in  1  port 1 request
req1_wr  in  1  port 1 write
req1_rd  in  1  port 1 read
req1_addr  in  AW  port 1 address
req1_din  in  DW  port 1 write data
rdy0  out  1  port 0 access complete (1-cycle pulse)
rdy1  out  1  port 1 access complete (1-cycle pulse)
gnt  out  2  one-hot current owner; 00 when idle
rd_data  out  DW  last read data, shared by both ports
busy  out  1  arbiter not in IDLE
mem_cs  out  1  memory chip select
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe
mem_addr  out  AW  memory address
mem_din  out  DW  memory write data
mem_dy  in  DW  memory read data

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last=1, counter=0.
  - All outputs 0, including rd_data.
  - An in-flight access is aborted; no rdy is issued.
- Valid request: reqN_cs=1 and (reqN_wr | reqN_rd).
  - wr and rd both 1: treated as a write.
  - cs without wr/rd: ignored.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - No valid request: stay in IDLE.
  - One valid request: grant that port.
  - Both valid: grant the port != last.
  - On grant: latch owner, wr flag, addr, din; last<=owner; counter<=ACC_CYC-1; go to ACCESS.
- ACCESS:
  - mem_cs=1, mem_wr=latched wr, mem_rd=!latched wr.
  - mem_addr/mem_din driven from latched values; requester inputs are don't-care after grant.
  - Counter decrements each cycle.
  - When counter==0: if read, rd_data<=mem_dy; go to DONE.
  - ACCESS lasts exactly ACC_CYC cycles.
- DONE:
  - rdyN=1 for the owner only; mem_* = 0.
  - Next state is IDLE unconditionally.
- gnt: one-hot owner during ACCESS and DONE; 00 in IDLE.
- busy = (state != IDLE).
- Latency: request sampled in IDLE at cycle t -> ACCESS t+1..t+ACC_CYC -> rdy at t+ACC_CYC+1.
- Minimum access period per port is ACC_CYC+2 cycles.
- Requester contract:
  - Drop cs in the cycle after rdy.
  - If cs is still high in the following IDLE cycle, it counts as a new back-to-back request.
- Fairness: under continuous contention the grant alternates 0,1,0,1. Starvation-free.
- A request arriving during ACCESS/DONE waits; it is evaluated only in IDLE.
- rd_data holds its value across writes and idle periods.
- All mem_* outputs are registered (glitch-free); the memory sees no combinational path from req inputs.

Decomposition:
- Shared package dm_bus_pkg:
  - State encoding IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Port ids P_CPU=0, P_AUX=1.
  - Counter width localparam CW=4.
- One natural sub-module, rr_pick2: combinational 2-way round-robin.
  - Inputs: v0, v1, last.
  - Outputs: sel, any.
- FSM, latches, and counter remain in dm_bus_arbiter.

Test Plan:
- Reset with all inputs idle -> all outputs 0, gnt=00. Release reset -> state stays IDLE.
- Port 0 read, addr=0x10, mem_dy=0xDEADBEEF, ACC_CYC=2:
  - mem_cs/mem_rd high for exactly 2 cycles with mem_addr=0x10.
  - rdy0 pulses 3 cycles after the request.
  - rd_data=0xDEADBEEF.
- Both ports raise write requests in the same cycle after reset:
  - Port 0 is granted first, then port 1.
  - mem_din = req0_din, then req1_din.
  - Exactly one rdy0 pulse, then one rdy1 pulse.
- Both ports hold cs continuously for 6 accesses -> gnt sequence 01,10,01,10,01,10; no two consecutive grants to the same port.
- Port 1 write issued with cs, wr and rd all 1 -> mem_wr=1, mem_rd=0; rd_data unchanged from the prior read value.
- Assert reset in the 2nd ACCESS cycle -> mem_cs drops immediately, no rdy pulse; after release, a fresh port 1 request is granted normally.

Source files
------------

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared types for the data-memory bus arbiter.
// State encoding, port ids and counter width.
package dm_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic P_CPU = 1'b0;
   localparam logic P_AUX = 1'b1;

   localparam int CW = 4;

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// Requester and memory-side signal bundle for dm_bus_arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface dm_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req0_cs;
   logic          req0_wr;
   logic          req0_rd;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_din;
   logic          req1_cs;
   logic          req1_wr;
   logic          req1_rd;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_din;
   logic          rdy0;
   logic          rdy1;
   logic [1:0]    gnt;
   logic [DW-1:0] rd_data;
   logic          busy;
   logic          mem_cs;
   logic          mem_wr;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dy;

   modport slave (
      input  req0_cs, req0_wr, req0_rd, req0_addr, req0_din,
      input  req1_cs, req1_wr, req1_rd, req1_addr, req1_din,
      input  mem_dy,
      output rdy0, rdy1, gnt, rd_data, busy,
      output mem_cs, mem_wr, mem_rd, mem_addr, mem_din
   );

   modport master (
      output req0_cs, req0_wr, req0_rd, req0_addr, req0_din,
      output req1_cs, req1_wr, req1_rd, req1_addr, req1_din,
      output mem_dy,
      input  rdy0, rdy1, gnt, rd_data, busy,
      input  mem_cs, mem_wr, mem_rd, mem_addr, mem_din
   );
endinterface

// File: rtl/dm_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the port that
// did not win last time is selected.
module rr_pick2
   import dm_bus_pkg::*;
(
   input  logic v0,
   input  logic v1,
   input  logic last,
   output logic sel,
   output logic any
);

   assign any = v0 | v1;

   always_comb begin
      sel = P_CPU;
      unique case (1'b1)
         (v0 & v1):  sel = ~last;
         (v1 & ~v0): sel = P_AUX;
         default:    sel = P_CPU;
      endcase
   end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Arbiter/sequencer for the shared data-memory bus:
// grant, fixed-length strobe window, read latch, rdy pulse.
module dm_bus_arbiter
   import dm_bus_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int ACC_CYC = 2
) (
   input logic             clk,
   input logic             reset,
   dm_bus_arbiter_if.slave bus
);

   localparam logic [CW-1:0] CNT_INIT = CW'(ACC_CYC - 1);

   state_t        state;
   logic          last;
   logic [CW-1:0] cnt;
   logic          v0, v1, sel, any;

   assign v0 = bus.req0_cs & (bus.req0_wr | bus.req0_rd);
   assign v1 = bus.req1_cs & (bus.req1_wr | bus.req1_rd);

   rr_pick2 u_pick (
      .v0   (v0),
      .v1   (v1),
      .last (last),
      .sel  (sel),
      .any  (any)
   );

   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         last         <= P_AUX;
         cnt          <= '0;
         bus.gnt      <= 2'b00;
         bus.rdy0     <= 1'b0;
         bus.rdy1     <= 1'b0;
         bus.rd_data  <= {DW{1'b0}};
         bus.mem_cs   <= 1'b0;
         bus.mem_wr   <= 1'b0;
         bus.mem_rd   <= 1'b0;
         bus.mem_addr <= {AW{1'b0}};
         bus.mem_din  <= {DW{1'b0}};
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  state      <= ACCESS;
                  last       <= sel;
                  cnt        <= CNT_INIT;
                  bus.gnt    <= sel ? 2'b10 : 2'b01;
                  bus.mem_cs <= 1'b1;
                  // wr wins when both strobes are set
                  if (sel == P_AUX) begin
                     bus.mem_wr   <= bus.req1_wr;
                     bus.mem_rd   <= ~bus.req1_wr;
                     bus.mem_addr <= bus.req1_addr;
                     bus.mem_din  <= bus.req1_din;
                  end else begin
                     bus.mem_wr   <= bus.req0_wr;
                     bus.mem_rd   <= ~bus.req0_wr;
                     bus.mem_addr <= bus.req0_addr;
                     bus.mem_din  <= bus.req0_din;
                  end
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  if (bus.mem_rd) bus.rd_data <= bus.mem_dy;
                  state        <= DONE;
                  bus.rdy0     <= bus.gnt[0];
                  bus.rdy1     <= bus.gnt[1];
                  bus.mem_cs   <= 1'b0;
                  bus.mem_wr   <= 1'b0;
                  bus.mem_rd   <= 1'b0;
                  bus.mem_addr <= {AW{1'b0}};
                  bus.mem_din  <= {DW{1'b0}};
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.gnt  <= 2'b00;
               bus.rdy0 <= 1'b0;
               bus.rdy1 <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Randomized bench for dm_bus_arbiter against a
// timestamp-based transaction model of the bus.
module tb_dm_bus_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int ACC = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dm_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dm_bus_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(ACC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // model: one grant record with its start cycle
   int            cyc = 0;
   bit            g_valid;
   int            g_start;
   int            g_port;
   bit            g_wr;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_din;
   int            free_at;
   int            m_last;
   logic [DW-1:0] m_rd;

   // requester agents and driven values
   bit            a_on [2];
   bit            a_gr [2];
   bit            a_wr [2];
   bit            a_rd [2];
   logic [AW-1:0] a_addr [2];
   logic [DW-1:0] a_din [2];
   bit            directed, keep_on, fix_dy;
   logic [DW-1:0] dy_fixed;
   int            rate;
   bit            d_cs [2];
   bit            d_wr [2];
   bit            d_rd [2];
   logic [AW-1:0] d_addr [2];
   logic [DW-1:0] d_din [2];
   logic [DW-1:0] d_dy;

   function automatic int phase_at(int c);
      if (!g_valid) return 0;
      if (c > g_start && c <= g_start + ACC) return 1;
      if (c == g_start + ACC + 1) return 2;
      return 0;
   endfunction

   task automatic apply_inputs();
      bus.req0_cs   = d_cs[0];
      bus.req0_wr   = d_wr[0];
      bus.req0_rd   = d_rd[0];
      bus.req0_addr = d_addr[0];
      bus.req0_din  = d_din[0];
      bus.req1_cs   = d_cs[1];
      bus.req1_wr   = d_wr[1];
      bus.req1_rd   = d_rd[1];
      bus.req1_addr = d_addr[1];
      bus.req1_din  = d_din[1];
      bus.mem_dy    = d_dy;
   endtask

   task automatic check_outputs();
      int ph;
      logic [1:0] e_gnt;
      ph = phase_at(cyc);
      e_gnt = (ph != 0) ? (g_port == 1 ? 2'b10 : 2'b01) : 2'b00;
      check("gnt", bus.gnt, e_gnt);
      check("busy", bus.busy, ph != 0);
      check("mem_cs", bus.mem_cs, ph == 1);
      check("mem_wr", bus.mem_wr, ph == 1 && g_wr);
      check("mem_rd", bus.mem_rd, ph == 1 && !g_wr);
      check("mem_addr", bus.mem_addr, ph == 1 ? g_addr : '0);
      check("mem_din", bus.mem_din, ph == 1 ? g_din : '0);
      check("rdy0", bus.rdy0, ph == 2 && g_port == 0);
      check("rdy1", bus.rdy1, ph == 2 && g_port == 1);
      check("rd_data", bus.rd_data, m_rd);
   endtask

   task automatic new_fields(input int p);
      a_wr[p]   = 1'($urandom_range(1));
      a_rd[p]   = a_wr[p] ? 1'($urandom_range(1)) : 1'b1;
      a_addr[p] = $urandom;
      a_din[p]  = $urandom;
   endtask

   task automatic drive_inputs();
      int ph;
      bit noise;
      ph = phase_at(cyc);
      for (int p = 0; p < 2; p++) begin
         noise = 1'b0;
         if (a_gr[p] && ph == 2 && g_port == p) begin
            a_gr[p] = 1'b0;
            if (directed) a_on[p] = keep_on;
            else begin
               a_on[p] = ($urandom_range(3) == 0);
               if (a_on[p]) new_fields(p);
            end
         end else if (!a_on[p] && !directed &&
                      $urandom_range(99) < rate) begin
            if ($urandom_range(4) == 0) noise = 1'b1;
            else begin
               a_on[p] = 1'b1;
               new_fields(p);
            end
         end
         if (a_on[p] && a_gr[p]) begin
            d_cs[p]   = 1'b1;
            d_wr[p]   = 1'($urandom_range(1));
            d_rd[p]   = 1'($urandom_range(1));
            d_addr[p] = $urandom;
            d_din[p]  = $urandom;
         end else if (a_on[p]) begin
            d_cs[p]   = 1'b1;
            d_wr[p]   = a_wr[p];
            d_rd[p]   = a_rd[p];
            d_addr[p] = a_addr[p];
            d_din[p]  = a_din[p];
         end else begin
            d_cs[p]   = noise;
            d_wr[p]   = 1'b0;
            d_rd[p]   = 1'b0;
            d_addr[p] = $urandom;
            d_din[p]  = $urandom;
         end
      end
      d_dy = fix_dy ? dy_fixed : DW'($urandom);
      apply_inputs();
   endtask

   task automatic model_update();
      bit v [2];
      int s;
      if (phase_at(cyc) == 1 && cyc == g_start + ACC && !g_wr)
         m_rd = d_dy;
      if (cyc >= free_at) begin
         for (int p = 0; p < 2; p++)
            v[p] = d_cs[p] && (d_wr[p] || d_rd[p]);
         if (v[0] || v[1]) begin
            if (v[0] && v[1]) s = (m_last == 0) ? 1 : 0;
            else s = v[1] ? 1 : 0;
            g_valid = 1'b1;
            g_start = cyc;
            g_port  = s;
            g_wr    = d_wr[s];
            g_addr  = d_addr[s];
            g_din   = d_din[s];
            free_at = cyc + ACC + 2;
            m_last  = s;
            a_gr[s] = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      check_outputs();
      drive_inputs();
      model_update();
   endtask

   task automatic zero_outputs_check(input string tag);
      check({tag, "_gnt"}, bus.gnt, 2'b00);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_mem_cs"}, bus.mem_cs, 1'b0);
      check({tag, "_mem_wr"}, bus.mem_wr, 1'b0);
      check({tag, "_mem_rd"}, bus.mem_rd, 1'b0);
      check({tag, "_mem_addr"}, bus.mem_addr, '0);
      check({tag, "_mem_din"}, bus.mem_din, '0);
      check({tag, "_rdy"}, {bus.rdy1, bus.rdy0}, 2'b00);
      check({tag, "_rd_data"}, bus.rd_data, '0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int p = 0; p < 2; p++) begin
         d_cs[p] = 0; d_wr[p] = 0; d_rd[p] = 0;
         d_addr[p] = '0; d_din[p] = '0;
         a_on[p] = 0; a_gr[p] = 0;
      end
      d_dy = '0;
      apply_inputs();
      #1;
      zero_outputs_check("rst_async");
      repeat (2) @(negedge clk);
      zero_outputs_check("rst_hold");
      g_valid = 1'b0;
      free_at = 0;
      m_last  = 1;
      m_rd    = '0;
      cyc     = 0;
      reset   = 1'b1;
   endtask

   initial begin
      logic [1:0] gseq [$];
      logic [1:0] prev;
      logic [1:0] exp_g;
      bit found;
      int rdy1_seen;

      directed = 1'b1; keep_on = 1'b0; fix_dy = 1'b0;
      rate = 0; dy_fixed = '0;
      do_reset();
      repeat (3) step();

      // port 0 read of 0x10
      fix_dy = 1'b1; dy_fixed = 32'hDEADBEEF;
      a_on[0] = 1; a_wr[0] = 0; a_rd[0] = 1;
      a_addr[0] = 32'h10; a_din[0] = 32'h0;
      repeat (7) step();
      check("dir_read_data", bus.rd_data, 32'hDEADBEEF);

      // port 1 write with both strobes set
      fix_dy = 1'b0;
      a_on[1] = 1; a_wr[1] = 1; a_rd[1] = 1;
      a_addr[1] = 32'h20; a_din[1] = 32'h12345678;
      repeat (7) step();
      check("wr_keeps_rd_data", bus.rd_data, 32'hDEADBEEF);

      // simultaneous writes after reset: port 0 first
      do_reset();
      a_on[0] = 1; a_wr[0] = 1; a_rd[0] = 0;
      a_addr[0] = 32'h100; a_din[0] = 32'hAAAA0000;
      a_on[1] = 1; a_wr[1] = 1; a_rd[1] = 0;
      a_addr[1] = 32'h200; a_din[1] = 32'hBBBB1111;
      repeat (12) step();

      // continuous contention: grants alternate
      do_reset();
      keep_on = 1'b1;
      for (int p = 0; p < 2; p++) begin
         a_on[p] = 1; a_wr[p] = 1; a_rd[p] = 0;
         a_addr[p] = 32'h40 + p; a_din[p] = 32'h5 + p;
      end
      prev = 2'b00;
      for (int i = 0; i < (ACC + 2) * 6 + 4; i++) begin
         step();
         if (bus.gnt != 2'b00 && prev == 2'b00) gseq.push_back(bus.gnt);
         prev = bus.gnt;
      end
      check("contention_grants", 64'(gseq.size() >= 6), 64'd1);
      for (int i = 0; i < 6 && i < gseq.size(); i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         check($sformatf("contention_gnt%0d", i), gseq[i], exp_g);
      end
      keep_on = 1'b0;
      for (int p = 0; p < 2; p++) a_on[p] = 0;
      repeat (ACC + 4) step();

      // randomized traffic at several load levels
      directed = 1'b0;
      for (int r = 0; r < 4; r++) begin
         rate = (r == 0) ? 10 : (r == 1) ? 40 : (r == 2) ? 80 : 100;
         repeat (500) step();
      end

      // reset in the second access cycle
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (phase_at(cyc) == 1 && cyc == g_start + 2) found = 1'b1;
      end
      check("midreset_found", found, 1'b1);
      do_reset();
      directed = 1'b1;
      repeat (2) step();
      a_on[1] = 1; a_wr[1] = 0; a_rd[1] = 1;
      a_addr[1] = 32'h300; a_din[1] = 32'h0;
      rdy1_seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.rdy1) rdy1_seen++;
      end
      check("post_reset_rdy1_count", rdy1_seen, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
